// File: rtl/literal_gen_pkg.sv
// rtl/literal_gen_pkg.sv - constants shared by literal_gen, debounce_bit and the bench
`include "literal_defs.vh"

package literal_gen_pkg;

  localparam int   SYNC_STAGES_DEF = `LIT_SYNC_STAGES_DEF;
  localparam int   DB_CYCLES_DEF   = `LIT_DB_CYCLES_DEF;
  localparam logic RST_TRUE        = `LIT_RST_TRUE;
  localparam logic RST_COMP        = `LIT_RST_COMP;
  localparam int   N_LIT           = 4;

  // Bit positions of the literals inside the packed true-value vector
  typedef enum logic [1:0] {
    LIT_A = 2'd0,
    LIT_B = 2'd1,
    LIT_C = 2'd2,
    LIT_D = 2'd3
  } lit_idx_e;

endpackage

// File: rtl/literal_defs.vh
// rtl/literal_defs.vh - shared defaults and reset literal values for literal_gen
`ifndef LITERAL_DEFS_VH
`define LITERAL_DEFS_VH

`define LIT_SYNC_STAGES_DEF 2
`define LIT_DB_CYCLES_DEF   4
`define LIT_RST_TRUE        1'b0
`define LIT_RST_COMP        1'b1

`endif

// File: rtl/literal_gen_debounce_bit.sv
// rtl/literal_gen_debounce_bit.sv - synchronizer chain plus consecutive-edge debounce for one bit
module debounce_bit
  import literal_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt_d
);

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q;
  logic [3:0]             cnt_q;
  logic [3:0]             cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: the raw level is never used before the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Next filtered value and counter: toggle on the DB_CYCLES-th consecutive differing edge
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q >= DB_LAST) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Filter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/literal_gen.sv
// rtl/literal_gen.sv - debounced true/complement literal generator with hold, change pulse and warm-up valid
module literal_gen
  import literal_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_c,
  input  logic raw_d,
  input  logic hold,
  output logic A,
  output logic Ab,
  output logic B,
  output logic Bb,
  output logic C,
  output logic Db,
  output logic valid,
  output logic chg
);

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  logic [N_LIT-1:0]       raw_vec;
  logic [N_LIT-1:0]       filt_d;
  logic [N_LIT-1:0]       lit_load;
  logic [N_LIT-1:0]       lit_q;
  // Complement flops for the D, B and A literals, in that order
  logic [2:0]             lit_n_q;
  logic [SYNC_STAGES-1:0] warm_pipe;
  logic [3:0]             warm_cnt;

  assign raw_vec = {raw_d, raw_c, raw_b, raw_a};

  for (genvar gi = 0; gi < N_LIT; gi++) begin : g_db
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_vec[gi]),
      .filt_d(filt_d[gi])
    );
  end

  // Outputs follow the filter's next value so they update on the same edge it toggles
  always_comb begin
    lit_load = lit_q;
    if (!hold) begin
      lit_load = filt_d;
    end
  end

  // Literal registers: true and complement flops load together; chg gated by pre-edge valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lit_q   <= {N_LIT{RST_TRUE}};
      lit_n_q <= {3{RST_COMP}};
      chg     <= 1'b0;
    end else begin
      lit_q   <= lit_load;
      lit_n_q <= ~{lit_load[LIT_D], lit_load[LIT_B], lit_load[LIT_A]};
      chg     <= valid && (lit_load != lit_q);
    end
  end

  // Warm-up: a shift chain covers the sync depth, a 4-bit counter covers the debounce depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_pipe <= '0;
      warm_cnt  <= '0;
      valid     <= 1'b0;
    end else begin
      warm_pipe <= {warm_pipe[SYNC_STAGES-2:0], 1'b1};
      if (warm_pipe[SYNC_STAGES-1] && !valid) begin
        if (warm_cnt >= DB_LAST) begin
          valid <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 4'd1;
        end
      end
    end
  end

  assign A  = lit_q[LIT_A];
  assign Ab = lit_n_q[0];
  assign B  = lit_q[LIT_B];
  assign Bb = lit_n_q[1];
  assign C  = lit_q[LIT_C];
  assign Db = lit_n_q[2];

endmodule

// File: doc/literal_gen.md
LITERAL_GEN -- requirements
Module: literal_gen

Interface
REQ-001 The parameter SYNC_STAGES SHALL have default 2 and SHALL set the synchronizer depth per input (legal: 2..3).
REQ-002 The parameter DB_CYCLES SHALL have default 4 and SHALL set the consecutive-edge debounce threshold per input (legal: 2..15).
REQ-003 The block SHALL have one clock, clk, an input of width 1 that is the single rising-edge clock.
REQ-004 The block SHALL have rst_n, an input of width 1 that is the asynchronous, active-low reset.
REQ-005 raw_a, raw_b, raw_c and raw_d SHALL each be an input of width 1 carrying an asynchronous raw level.
REQ-006 hold SHALL be an input of width 1 that freezes the literal outputs while high.
REQ-007 A, Ab, B, Bb, C and Db SHALL each be an output of width 1, registered, forming debounced true/complement literals (Db = complement of debounced D).
REQ-008 valid SHALL be an output of width 1 that goes high once post-reset warm-up completes.
REQ-009 chg SHALL be an output of width 1 that pulses for one cycle when any literal output changes.

Function
REQ-010 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-011 Per input: a counter SHALL increment at each edge where the synchronized value differs from the filtered value, and SHALL clear at any edge where they are equal.
REQ-012 The filtered value SHALL toggle, and its counter clear, at the DB_CYCLES-th consecutive differing edge.
REQ-013 A raw level stable from before edge 1 SHALL appear on the outputs at edge SYNC_STAGES+DB_CYCLES (6 with defaults) when hold=0.
REQ-014 A synchronized pulse shorter than DB_CYCLES cycles SHALL produce no output change.
REQ-015 The pairs A/Ab, B/Bb and C/(true D)/Db SHALL be complementary in every cycle, including during and immediately after reset; both members of a pair SHALL update on the same edge.
REQ-016 While hold=1, the outputs SHALL keep their values, and filtering SHALL continue.
REQ-017 On the first edge with hold=0, the outputs SHALL load the current filtered values.
REQ-018 chg SHALL be high for exactly the cycle in which any output literal first shows a new value, and only if valid=1.
REQ-019 Simultaneous changes on multiple literals SHALL produce a single one-cycle chg pulse.
REQ-020 A warm-up counter SHALL assert valid at edge SYNC_STAGES+DB_CYCLES after rst_n deasserts; valid SHALL then stay high until reset.
REQ-021 Counters SHALL saturate and never wrap; no counter width SHALL exceed 4 bits.

Reset
REQ-022 rst_n=0 SHALL immediately force A=0, Ab=1, B=0, Bb=1, C=0, Db=1, valid=0 and chg=0, and SHALL clear all synchronizer, filter and counter state to 0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after release, filtering SHALL restart from filtered=0.

Structure
REQ-024 The defaults for SYNC_STAGES and DB_CYCLES and the reset literal values SHALL be defined in a shared include file, literal_defs.vh, used by this block and its bench.
REQ-025 Synchronizer plus debounce for one bit SHALL be a sub-module, debounce_bit, instantiated four times; output registering, hold, chg and valid logic SHALL stay in literal_gen.

Verification
REQ-026 The bench SHALL cover: reset, then raw_a=1 held -> valid rises at edge 6; A=1/Ab=0 at edge 6; chg=0 (update coincides with warm-up, not after).
REQ-027 The bench SHALL cover: after valid, raw_b 0->1 held -> B=1/Bb=0 exactly 6 edges later, with a single chg pulse.
REQ-028 The bench SHALL cover: after valid, a 3-cycle raw_c pulse -> C stays 0 and chg stays 0.
REQ-029 The bench SHALL cover: hold=1, then raw_d=1 for 10 cycles -> Db stays 1; hold=0 -> Db=0 on the next edge, with one chg pulse.
REQ-030 The bench SHALL cover: raw_a and raw_d changed on the same cycle -> both pairs update on one edge with one chg pulse; complementarity is checked every cycle.
REQ-031 The bench SHALL cover: rst_n pulsed low at count 2 of a raw_b change -> outputs immediately at reset values; the change appears only 6 edges after release if raw_b stays 1.
